// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the Galois LFSR random-number generator:
// FSM state encoding, the single-step Galois function and the maximal-length tap table.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SPIN = 2'd1,
    ST_HOLD = 2'd2
  } lfsr_state_t;

  // Right-shifting Galois step; callers zero-extend to 32 bits and truncate back.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

  // Maximal-length Galois feedback masks for widths 3..32 (zero for illegal widths).
  function automatic logic [31:0] maxlen_taps(input int unsigned width);
    logic [31:0] t;
    t = '0;
    case (width)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_0009;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0E08;
      13: t = 32'h0000_1C80;
      14: t = 32'h0000_3802;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_B400;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0007_2000;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with Galois step, runtime seed load and all-zero lock-up protection.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(maxlen_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Step,
  input  logic             Seed_Load,
  input  logic [WIDTH-1:0] Seed_In,
  output logic [WIDTH-1:0] State
);

  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_step;

  assign lfsr_step = WIDTH'(lfsr_next(32'(lfsr_q), 32'(TAPS)));

  // A zero seed or a corrupted zero state both fall back to SEED.
  always_comb begin
    lfsr_d = lfsr_q;
    if (Seed_Load) begin
      lfsr_d = (Seed_In == '0) ? SEED : Seed_In;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (Step) begin
      lfsr_d = lfsr_step;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign State = lfsr_q;

endmodule

// File: rtl/lfsr_rand_gen.sv
// Range-limited random value generator: rejection-samples the LFSR into [0, MAX_VAL]
// and presents accepted values on a valid/ready handshake.
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(maxlen_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = '1,
  parameter int unsigned      OUT_W     = 6,
  parameter int unsigned      MAX_VAL   = 63,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Seed_Load,
  input  logic [WIDTH-1:0] Seed_In,
  input  logic             Req,
  output logic [OUT_W-1:0] Rand_Out,
  output logic             Valid,
  input  logic             Ready,
  output logic             Busy,
  output logic             Timeout,
  output logic [WIDTH-1:0] Lfsr_State
);

  localparam int unsigned      TRY_W    = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_VAL);

  lfsr_state_t      state_d, state_q;
  logic [TRY_W-1:0] try_d, try_q;
  logic [OUT_W-1:0] rand_d, rand_q;
  logic             valid_d, valid_q;
  logic             timeout_d, timeout_q;
  logic             lfsr_step;
  logic [OUT_W-1:0] cand;

  assign lfsr_step = En | (state_q == ST_SPIN);

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .Clk       (Clk),
    .Rst       (Rst),
    .Step      (lfsr_step),
    .Seed_Load (Seed_Load),
    .Seed_In   (Seed_In),
    .State     (Lfsr_State)
  );

  // Candidate comes from the registered state, so a same-cycle seed load affects the next one.
  assign cand = Lfsr_State[OUT_W-1:0];

  always_comb begin
    state_d   = state_q;
    try_d     = try_q;
    rand_d    = rand_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          state_d = ST_SPIN;
          try_d   = '0;
        end
      end
      ST_SPIN: begin
        if (cand <= MAX_OUT) begin
          rand_d  = cand;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (try_q == TRY_LAST) begin
          rand_d    = MAX_OUT;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      ST_HOLD: begin
        if (valid_q && Ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      try_q     <= '0;
      rand_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      try_q     <= try_d;
      rand_q    <= rand_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Rand_Out = rand_q;
  assign Valid    = valid_q;
  assign Timeout  = timeout_q;
  assign Busy     = (state_q == ST_SPIN);

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: default, narrowed-range and timeout configurations
// share stimulus; each scenario task checks hand-computed values.
module tb_lfsr_rand_gen;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       En = 1'b0;
  logic       Seed_Load = 1'b0;
  logic [7:0] Seed_In = 8'h00;
  logic       Req = 1'b0;
  logic       Ready = 1'b0;

  logic [5:0] rand_a, rand_b, rand_c;
  logic       valid_a, valid_b, valid_c;
  logic       busy_a, busy_b, busy_c;
  logic       to_a, to_b, to_c;
  logic [7:0] lfsr_a, lfsr_b, lfsr_c;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  lfsr_rand_gen u_dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .Seed_Load(Seed_Load), .Seed_In(Seed_In),
    .Req(Req), .Rand_Out(rand_a), .Valid(valid_a), .Ready(Ready),
    .Busy(busy_a), .Timeout(to_a), .Lfsr_State(lfsr_a)
  );

  lfsr_rand_gen #(.MAX_VAL(16)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .Seed_Load(Seed_Load), .Seed_In(Seed_In),
    .Req(Req), .Rand_Out(rand_b), .Valid(valid_b), .Ready(Ready),
    .Busy(busy_b), .Timeout(to_b), .Lfsr_State(lfsr_b)
  );

  lfsr_rand_gen #(.MAX_VAL(0), .MAX_TRIES(4)) u_dut_c (
    .Clk(Clk), .Rst(Rst), .En(En), .Seed_Load(Seed_Load), .Seed_In(Seed_In),
    .Req(Req), .Rand_Out(rand_c), .Valid(valid_c), .Ready(Ready),
    .Busy(busy_c), .Timeout(to_c), .Lfsr_State(lfsr_c)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; En = 1'b0; Seed_Load = 1'b0; Seed_In = 8'h00; Req = 1'b0; Ready = 1'b0;
    step();
    step();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    tests++; if (to_a !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", to_a); end
    tests++; if (rand_a !== 6'h00) begin fails++; $display("FAIL reset_rand got %h exp 00", rand_a); end
    tests++; if (lfsr_a !== 8'hFF) begin fails++; $display("FAIL reset_lfsr got %h exp ff", lfsr_a); end
    tests++; if (lfsr_c !== 8'hFF) begin fails++; $display("FAIL reset_lfsr_c got %h exp ff", lfsr_c); end
  endtask

  task automatic test_basic_request();
    do_reset();
    Req = 1'b1; Ready = 1'b1;
    step();
    Req = 1'b0;
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_busy got %b exp 1", busy_a); end
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL basic_valid_early got %b exp 0", valid_a); end
    step();
    tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", valid_a); end
    tests++; if (rand_a !== 6'h3F) begin fails++; $display("FAIL basic_rand got %h exp 3f", rand_a); end
    tests++; if (lfsr_a !== 8'hC7) begin fails++; $display("FAIL basic_lfsr got %h exp c7", lfsr_a); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy_done got %b exp 0", busy_a); end
    step();
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL basic_consume got %b exp 0", valid_a); end
    Ready = 1'b0;
  endtask

  task automatic test_free_run();
    logic [7:0] exp_seq [5];
    int zero_seen;
    int early_wrap;
    exp_seq = '{8'hFF, 8'hC7, 8'hDB, 8'hD5, 8'hD2};
    zero_seen = 0;
    early_wrap = 0;
    do_reset();
    En = 1'b1;
    tests++; if (lfsr_a !== exp_seq[0]) begin fails++; $display("FAIL run_seq0 got %h exp %h", lfsr_a, exp_seq[0]); end
    for (int i = 1; i < 5; i++) begin
      step();
      tests++; if (lfsr_a !== exp_seq[i]) begin fails++; $display("FAIL run_seq%0d got %h exp %h", i, lfsr_a, exp_seq[i]); end
    end
    for (int i = 5; i <= 255; i++) begin
      step();
      if (lfsr_a == 8'h00) zero_seen++;
      if (i < 255 && lfsr_a == 8'hFF) early_wrap++;
    end
    En = 1'b0;
    tests++; if (lfsr_a !== 8'hFF) begin fails++; $display("FAIL run_period got %h exp ff", lfsr_a); end
    tests++; if (zero_seen !== 0) begin fails++; $display("FAIL run_zero got %0d exp 0", zero_seen); end
    tests++; if (early_wrap !== 0) begin fails++; $display("FAIL run_early_wrap got %0d exp 0", early_wrap); end
  endtask

  task automatic test_reject();
    do_reset();
    Req = 1'b1;
    step();
    Req = 1'b0;
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL rej_busy1 got %b exp 1", busy_b); end
    step();
    tests++; if (busy_b !== 1'b1) begin fails++; $display("FAIL rej_busy2 got %b exp 1", busy_b); end
    tests++; if (valid_b !== 1'b0) begin fails++; $display("FAIL rej_valid_early got %b exp 0", valid_b); end
    step();
    tests++; if (valid_b !== 1'b1) begin fails++; $display("FAIL rej_valid got %b exp 1", valid_b); end
    tests++; if (rand_b !== 6'h07) begin fails++; $display("FAIL rej_rand got %h exp 07", rand_b); end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL rej_busy_done got %b exp 0", busy_b); end
    tests++; if (to_b !== 1'b0) begin fails++; $display("FAIL rej_timeout got %b exp 0", to_b); end
  endtask

  task automatic test_timeout();
    do_reset();
    Req = 1'b1;
    step();
    Req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++; if (busy_c !== 1'b1 || to_c !== 1'b0) begin fails++; $display("FAIL to_spin%0d busy %b to %b exp busy 1 to 0", i, busy_c, to_c); end
    end
    step();
    tests++; if (to_c !== 1'b1) begin fails++; $display("FAIL to_pulse got %b exp 1", to_c); end
    tests++; if (valid_c !== 1'b1) begin fails++; $display("FAIL to_valid got %b exp 1", valid_c); end
    tests++; if (rand_c !== 6'h00) begin fails++; $display("FAIL to_rand got %h exp 00", rand_c); end
    tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL to_busy got %b exp 0", busy_c); end
    tests++; if (lfsr_c !== 8'hD2) begin fails++; $display("FAIL to_lfsr got %h exp d2", lfsr_c); end
    step();
    tests++; if (to_c !== 1'b0) begin fails++; $display("FAIL to_pulse_end got %b exp 0", to_c); end
    tests++; if (valid_c !== 1'b1) begin fails++; $display("FAIL to_valid_held got %b exp 1", valid_c); end
  endtask

  task automatic test_seed_load();
    do_reset();
    Seed_Load = 1'b1; Seed_In = 8'h5A;
    step();
    tests++; if (lfsr_a !== 8'h5A) begin fails++; $display("FAIL seed_5a got %h exp 5a", lfsr_a); end
    Seed_In = 8'h00;
    step();
    tests++; if (lfsr_a !== 8'hFF) begin fails++; $display("FAIL seed_zero got %h exp ff", lfsr_a); end
    Seed_In = 8'h5A;
    step();
    Seed_Load = 1'b0; Req = 1'b1;
    step();
    Req = 1'b0;
    step();
    tests++; if (rand_a !== 6'h1A) begin fails++; $display("FAIL seed_rand got %h exp 1a", rand_a); end
    tests++; if (lfsr_a !== 8'h2D) begin fails++; $display("FAIL seed_step got %h exp 2d", lfsr_a); end
    Seed_Load = 1'b1; Seed_In = 8'h33;
    step();
    Seed_Load = 1'b0;
    tests++; if (lfsr_a !== 8'h33) begin fails++; $display("FAIL seed_hold_load got %h exp 33", lfsr_a); end
    tests++; if (rand_a !== 6'h1A) begin fails++; $display("FAIL seed_hold_rand got %h exp 1a", rand_a); end
    tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL seed_hold_valid got %b exp 1", valid_a); end
    tests++; if (lfsr_c !== 8'h33) begin fails++; $display("FAIL seed_spin_load got %h exp 33", lfsr_c); end
    tests++; if (busy_c !== 1'b1) begin fails++; $display("FAIL seed_spin_busy got %b exp 1", busy_c); end
    Ready = 1'b1;
    step();
    Ready = 1'b0;
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL seed_consume got %b exp 0", valid_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    Req = 1'b1;
    step();
    Req = 1'b0;
    step();
    Req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if (valid_a !== 1'b1 || rand_a !== 6'h3F || busy_a !== 1'b0) begin
        fails++;
        $display("FAIL hold%0d valid %b rand %h busy %b exp 1 3f 0", i, valid_a, rand_a, busy_a);
      end
    end
    Req = 1'b0; Ready = 1'b1;
    step();
    Ready = 1'b0;
    tests++; if (valid_a !== 1'b0) begin fails++; $display("FAIL b2b_consume got %b exp 0", valid_a); end
    Req = 1'b1;
    step();
    Req = 1'b0;
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b exp 1", busy_a); end
    step();
    tests++; if (valid_a !== 1'b1) begin fails++; $display("FAIL b2b_valid got %b exp 1", valid_a); end
    tests++; if (rand_a !== 6'h07) begin fails++; $display("FAIL b2b_rand got %h exp 07", rand_a); end
  endtask

  task automatic test_reset_mid_spin();
    do_reset();
    Seed_Load = 1'b1; Seed_In = 8'h5A;
    step();
    Seed_Load = 1'b0; Req = 1'b1;
    step();
    Req = 1'b0;
    step();
    tests++; if (busy_c !== 1'b1) begin fails++; $display("FAIL mid_busy_pre got %b exp 1", busy_c); end
    Rst = 1'b0;
    step();
    tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy_c); end
    tests++; if (valid_c !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", valid_c); end
    tests++; if (lfsr_c !== 8'hFF) begin fails++; $display("FAIL mid_lfsr got %h exp ff", lfsr_c); end
    tests++; if (valid_a !== 1'b0 || rand_a !== 6'h00) begin fails++; $display("FAIL mid_hold_discard valid %b rand %h exp 0 00", valid_a, rand_a); end
    Rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic_request();
    test_free_run();
    test_reject();
    test_timeout();
    test_seed_load();
    test_back_to_back();
    test_reset_mid_spin();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
